barrel_shift_pipe: RTL and testbench



---
 rtl/barrel_shift_pipe.sv | 124 ++++++++++++
 tb/tb_barrel_shift_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe
//   Pipelined barrel shifter for any power-of-two WIDTH. Supports rotate,
//   logical shift and arithmetic shift, left or right, by 0..WIDTH-1.
//   There are $clog2(WIDTH) register stages. Stage i applies a shift of
//   2^i when bit i of the carried amount is set. The whole pipeline
//   advances together, or holds when the consumer stalls a valid result.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears all stage state)
//   in_data    operand
//   in_amt     shift magnitude, 0..WIDTH-1
//   in_dir     0 = right, 1 = left
//   in_mode    00 rotate, 01 logical, 10 arithmetic, 11 treated as rotate
//   in_valid   operand valid
//   in_ready   operand accepted this cycle (combinational from out side)
//   out_data   result
//   out_valid  result valid
//   out_ready  consumer accepts result
module barrel_shift_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic                       in_dir,
  input  logic [1:0]                 in_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int SHW = $clog2(WIDTH);

  // Shift d by 2^k. The arithmetic fill uses the operand's original MSB
  // (sign), because earlier stages may already have changed the current MSB.
  function automatic logic [WIDTH-1:0] shift_pow2(
    input logic [WIDTH-1:0] d,
    input int               k,
    input logic             dir,
    input logic [1:0]       mode,
    input logic             sign
  );
    int               sh;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    sh   = 1 << k;
    fill = ~({WIDTH{1'b1}} >> sh);
    case (mode)
      2'b01:   r = dir ? (d << sh) : (d >> sh);
      2'b10:   r = dir ? (d << sh) : ((d >> sh) | (sign ? fill : '0));
      default: r = dir ? ((d << sh) | (d >> (WIDTH - sh)))
                       : ((d >> sh) | (d << (WIDTH - sh)));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] data_p [SHW];
  logic [SHW-1:0]   amt_p  [SHW];
  logic             dir_p  [SHW];
  logic [1:0]       mode_p [SHW];
  logic             sign_p [SHW];
  logic             vld_p  [SHW];

  // Source fields feeding each stage register.
  logic [WIDTH-1:0] s_data [SHW];
  logic [SHW-1:0]   s_amt  [SHW];
  logic             s_dir  [SHW];
  logic [1:0]       s_mode [SHW];
  logic             s_sign [SHW];
  logic             s_vld  [SHW];

  logic advance;

  assign advance   = !vld_p[SHW-1] || out_ready;
  assign in_ready  = advance;
  assign out_data  = data_p[SHW-1];
  assign out_valid = vld_p[SHW-1];

  always_comb begin
    s_data[0] = in_data;
    s_amt[0]  = in_amt;
    s_dir[0]  = in_dir;
    s_mode[0] = in_mode;
    s_sign[0] = in_data[WIDTH-1];
    s_vld[0]  = in_valid;
    for (int i = 1; i < SHW; i++) begin
      s_data[i] = data_p[i-1];
      s_amt[i]  = amt_p[i-1];
      s_dir[i]  = dir_p[i-1];
      s_mode[i] = mode_p[i-1];
      s_sign[i] = sign_p[i-1];
      s_vld[i]  = vld_p[i-1];
    end
  end

  // Stage boundary: register i captures its source after the 2^i step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SHW; i++) begin
        data_p[i] <= '0;
        amt_p[i]  <= '0;
        dir_p[i]  <= 1'b0;
        mode_p[i] <= '0;
        sign_p[i] <= 1'b0;
        vld_p[i]  <= 1'b0;
      end
    end else if (advance) begin
      for (int i = 0; i < SHW; i++) begin
        data_p[i] <= s_amt[i][i] ? shift_pow2(s_data[i], i, s_dir[i], s_mode[i], s_sign[i])
                                 : s_data[i];
        amt_p[i]  <= s_amt[i];
        dir_p[i]  <= s_dir[i];
        mode_p[i] <= s_mode[i];
        sign_p[i] <= s_sign[i];
        vld_p[i]  <= s_vld[i];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic [7:0] a_data = '0;
  logic [2:0] a_amt = '0;
  logic       a_dir = 1'b0;
  logic [1:0] a_mode = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] y_data;
  logic       y_valid;
  logic       y_ready = 1'b1;

  // WIDTH=32 instance
  logic [31:0] b_data = '0;
  logic [4:0]  b_amt = '0;
  logic        b_dir = 1'b0;
  logic [1:0]  b_mode = '0;
  logic        b_valid = 1'b0;
  logic        b_in_ready;
  logic [31:0] z_data;
  logic        z_valid;
  logic        z_ready = 1'b1;

  barrel_shift_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_data(a_data), .in_amt(a_amt), .in_dir(a_dir),
    .in_mode(a_mode), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(y_data), .out_valid(y_valid), .out_ready(y_ready));

  barrel_shift_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_data(b_data), .in_amt(b_amt), .in_dir(b_dir),
    .in_mode(b_mode), .in_valid(b_valid), .in_ready(b_in_ready),
    .out_data(z_data), .out_valid(z_valid), .out_ready(z_ready));

  int n_pass = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference: plain arithmetic on the operand value.
  function automatic logic [63:0] model(input logic [63:0] d, input int amt, input logic dir,
                                         input logic [1:0] mode, input int w);
    longint unsigned m, pw, du;
    longint s, r;
    int l;
    m  = 64'd1 << w;
    pw = 64'd1 << amt;
    du = d % m;
    if (amt == 0) return du;
    if (mode == 2'b01 || (mode == 2'b10 && dir)) begin
      if (dir) return (du * pw) % m;
      return du / pw;
    end
    if (mode == 2'b10) begin
      s = (du >= m / 2) ? longint'(du) - longint'(m) : longint'(du);
      r = (s >= 0) ? s / longint'(pw) : -((-s + longint'(pw) - 1) / longint'(pw));
      return (r < 0) ? 64'(r + longint'(m)) : 64'(r);
    end
    l = dir ? amt : w - amt;
    return ((du * (64'd1 << l)) % m) | (du >> (w - l));
  endfunction

  // Scoreboard and compare process for the WIDTH=8 instance.
  logic [63:0] exp_q[$];
  int          retire_cyc[$];
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold valid", 64'(y_valid), 64'd1);
        check("hold data", 64'(y_data), 64'(prev_data));
      end
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) check("spurious result", 64'(y_valid), 64'd0);
        else begin
          check("result", 64'(y_data), exp_q.pop_front());
          retire_cyc.push_back(cyc);
        end
      end
      if (a_valid && a_ready)
        exp_q.push_back(model(64'(a_data), int'(a_amt), a_dir, a_mode, 8));
      prev_stall = y_valid && !y_ready;
      prev_data  = y_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] amt, input logic dir,
                       input logic [1:0] mode, input logic [7:0] lit, input string name);
    int lat;
    a_data = d; a_amt = amt; a_dir = dir; a_mode = mode; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    lat = 1;
    while (!y_valid && lat < 20) begin tick(); lat++; end
    check({name, " latency"}, 64'(lat), 64'd3);
    check({name, " data"}, 64'(y_data), 64'(lit));
    check({name, " model"}, model(64'(d), int'(amt), dir, mode, 8), 64'(lit));
    tick();
  endtask

  task automatic drain8();
    int t = 0;
    a_valid = 1'b0;
    y_ready = 1'b1;
    while ((exp_q.size() != 0 || y_valid) && t < 50) begin tick(); t++; end
    check("drain empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int stall_seen;
    logic [31:0] ar31;
    #1;
    check("reset out_valid", 64'(y_valid), 64'd0);
    check("reset out_data", 64'(y_data), 64'd0);
    check("reset in_ready", 64'(a_ready), 64'd1);
    check("reset out_valid w32", 64'(z_valid), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed vectors on 0xB1.
    send8(8'hB1, 3'd1, 1'b0, 2'b00, 8'hD8, "rot right 1");
    send8(8'hB1, 3'd3, 1'b1, 2'b00, 8'h8D, "rot left 3");
    send8(8'hB1, 3'd2, 1'b0, 2'b01, 8'h2C, "log right 2");
    send8(8'hB1, 3'd2, 1'b0, 2'b10, 8'hEC, "ari right 2");
    send8(8'hB1, 3'd4, 1'b1, 2'b01, 8'h10, "log left 4");
    send8(8'hB1, 3'd3, 1'b1, 2'b11, 8'h8D, "mode11 left 3");
    for (int m = 0; m < 4; m++)
      for (int d = 0; d < 2; d++)
        send8(8'hB1, 3'd0, d[0], m[1:0], 8'hB1, "amount 0");

    // Back-to-back stream of 16.
    retire_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      a_data = 8'($urandom); a_amt = 3'($urandom); a_dir = 1'($urandom);
      a_mode = 2'($urandom); a_valid = 1'b1;
      tick();
    end
    drain8();
    check("stream count", 64'(retire_cyc.size()), 64'd16);
    if (retire_cyc.size() == 16)
      check("stream consecutive", 64'(retire_cyc[15] - retire_cyc[0]), 64'd15);

    // Backpressure: 6 operands, out_ready low for 4 cycles after first result.
    retire_cyc.delete();
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 6; ) begin
          logic ok;
          a_data = 8'($urandom); a_amt = 3'($urandom); a_dir = 1'($urandom);
          a_mode = 2'($urandom); a_valid = 1'b1;
          @(negedge clk);
          ok = a_ready;
          tick();
          if (ok) i++;
        end
        a_valid = 1'b0;
      end
      begin
        int t = 0;
        while (!y_valid && t < 20) begin tick(); t++; end
        y_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (!a_ready) stall_seen++;
          tick();
        end
        y_ready = 1'b1;
      end
    join
    drain8();
    check("bp in_ready low cycles", 64'(stall_seen), 64'd4);
    check("bp count", 64'(retire_cyc.size()), 64'd6);
    if (retire_cyc.size() == 6)
      check("bp resume span", 64'(retire_cyc[5] - retire_cyc[0]), 64'd5);

    // Reset with two operands in flight.
    a_data = 8'h5A; a_amt = 3'd1; a_dir = 1'b1; a_mode = 2'b00; a_valid = 1'b1;
    tick();
    a_data = 8'hC3;
    tick();
    a_valid = 1'b0;
    tick();
    check("pre-reset out_valid", 64'(y_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async reset out_valid", 64'(y_valid), 64'd0);
    check("async reset out_data", 64'(y_data), 64'd0);
    check("async reset in_ready", 64'(a_ready), 64'd1);
    tick();
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (y_valid) n++;
    end
    check("no stale results", 64'(n), 64'd0);
    tick();

    // Randomised valid/ready on both sides.
    for (int c = 0; c < 10000; c++) begin
      a_data = 8'($urandom); a_amt = 3'($urandom); a_dir = 1'($urandom);
      a_mode = 2'($urandom); a_valid = 1'($urandom);
      y_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain8();

    // WIDTH=32 exhaustive amount x dir x mode on 0x8000_0001.
    ar31 = '0;
    for (int amt = 0; amt < 32; amt++)
      for (int d = 0; d < 2; d++)
        for (int m = 0; m < 4; m++) begin
          int lat;
          b_data = 32'h8000_0001; b_amt = amt[4:0]; b_dir = d[0]; b_mode = m[1:0];
          b_valid = 1'b1;
          tick();
          b_valid = 1'b0;
          lat = 1;
          while (!z_valid && lat < 20) begin tick(); lat++; end
          check("w32 latency", 64'(lat), 64'd5);
          check("w32 data", 64'(z_data), model(64'h8000_0001, amt, d[0], m[1:0], 32));
          if (amt == 31 && d == 0 && m == 2) ar31 = z_data;
          tick();
        end
    check("w32 ari right 31", 64'(ar31), 64'hFFFF_FFFF);
    check("w32 model ari right 31", model(64'h8000_0001, 31, 1'b0, 2'b10, 32), 64'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
